// File: rtl/booth_divider_1x_pkg.sv
// rtl/booth_divider_1x_pkg.sv - shared widths and sign helper for the radix-2 divider
package booth_divider_1x_pkg;

    localparam int DIV_N  = 16;
    localparam int DIV_CW = 5;
    localparam int NEG_W  = 64;

    // Callers zero-extend into NEG_W and cast the result back to their own width.
    function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x, input logic en);
        return en ? (~x + NEG_W'(1)) : x;
    endfunction

endpackage

// File: rtl/booth_divider_1x_if.sv
// rtl/booth_divider_1x_if.sv - Ld/Valid operand and result bundle for the divider
interface booth_divider_1x_if
    import booth_divider_1x_pkg::*;
#(
    parameter int N = DIV_N
);
    logic         Ld;
    logic         Sgn;
    logic [N-1:0] D;
    logic [N-1:0] V;
    logic         Busy;
    logic         Valid;
    logic [N-1:0] Q;
    logic [N-1:0] Rm;
    logic         DivZ;

    modport master (
        output Ld, Sgn, D, V,
        input  Busy, Valid, Q, Rm, DivZ
    );

    modport slave (
        input  Ld, Sgn, D, V,
        output Busy, Valid, Q, Rm, DivZ
    );
endinterface

// File: rtl/booth_divider_1x_div_step.sv
// rtl/booth_divider_1x_div_step.sv - one restoring trial-subtract step, purely combinational
module booth_divider_1x_div_step #(
    parameter int N = 16
) (
    input  logic [N:0]   rem_i,
    input  logic         q_msb_i,
    input  logic [N-1:0] dvs_i,
    output logic [N:0]   rem_o,
    output logic         q_bit_o
);
    logic [N+1:0] trial;

    // The guard bit of rem_i is always 0 while the divisor is nonzero, so the
    // wider subtraction yields the same sign as the N+1-bit trial.
    always_comb begin
        trial   = {rem_i, q_msb_i} - {2'b00, dvs_i};
        q_bit_o = ~trial[N+1];
        rem_o   = q_bit_o ? trial[N:0] : {rem_i[N-1:0], q_msb_i};
    end
endmodule

// File: rtl/booth_divider_1x.sv
// rtl/booth_divider_1x.sv - sequential radix-2 restoring divider, one quotient bit per clock
module booth_divider_1x
    import booth_divider_1x_pkg::*;
#(
    parameter int N  = DIV_N,
    parameter int CW = DIV_CW
) (
    input  logic             Clk,
    input  logic             Rst,
    booth_divider_1x_if.slave bus
);
    logic [CW-1:0] cntr_q, cntr_d;
    logic [N:0]    rem_q, rem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  draw_q, draw_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  rm_q, rm_d;
    logic          divz_q, divz_d;
    logic          valid_q, valid_d;

    logic [N:0]    step_rem;
    logic          step_qbit;
    logic [N-1:0]  q_next;
    logic [N-1:0]  r_next;
    logic          iterate;
    logic          last;

    booth_divider_1x_div_step #(.N(N)) u_step (
        .rem_i   (rem_q),
        .q_msb_i (quo_q[N-1]),
        .dvs_i   (dvs_q),
        .rem_o   (step_rem),
        .q_bit_o (step_qbit)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cntr_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            draw_q    <= '0;
            q_q       <= '0;
            rm_q      <= '0;
            divz_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            cntr_q    <= cntr_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            draw_q    <= draw_d;
            q_q       <= q_d;
            rm_q      <= rm_d;
            divz_q    <= divz_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        cntr_d    = cntr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        draw_d    = draw_q;
        q_d       = q_q;
        rm_d      = rm_q;
        divz_d    = divz_q;
        valid_d   = 1'b0;

        iterate = (cntr_q != '0) && !bus.Ld;
        last    = iterate && (cntr_q == CW'(1));
        q_next  = {quo_q[N-2:0], step_qbit};
        r_next  = step_rem[N-1:0];

        if (bus.Ld) begin
            cntr_d    = CW'(N);
            rem_d     = '0;
            quo_d     = N'(cond_neg(NEG_W'(bus.D), bus.Sgn & bus.D[N-1]));
            dvs_d     = N'(cond_neg(NEG_W'(bus.V), bus.Sgn & bus.V[N-1]));
            neg_quo_d = bus.Sgn & (bus.D[N-1] ^ bus.V[N-1]);
            neg_rem_d = bus.Sgn & bus.D[N-1];
            zero_d    = (bus.V == '0);
            draw_d    = bus.D;
        end else if (iterate) begin
            cntr_d = cntr_q - CW'(1);
            rem_d  = step_rem;
            quo_d  = q_next;
        end

        // Divide-by-zero runs the full N steps so latency never depends on data.
        if (last) begin
            valid_d = 1'b1;
            divz_d  = zero_q;
            if (zero_q) begin
                q_d  = '1;
                rm_d = draw_q;
            end else begin
                q_d  = N'(cond_neg(NEG_W'(q_next), neg_quo_q));
                rm_d = N'(cond_neg(NEG_W'(r_next), neg_rem_q));
            end
        end
    end

    always_comb begin
        bus.Busy  = (cntr_q != '0);
        bus.Valid = valid_q;
        bus.Q     = q_q;
        bus.Rm    = rm_q;
        bus.DivZ  = divz_q;
    end
endmodule
